// File: rtl/speaker_ctl_if.sv
// Stereo sample handoff from the tone generators plus the four DAC pins.
// The generator side is the master; speaker_ctl uses the slave modport.
interface speaker_ctl_if;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        mute;
    logic        sample_req;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;

    modport master (
        output audio_left, audio_right, mute,
        input  sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );

    modport slave (
        input  audio_left, audio_right, mute,
        output sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
endinterface

// File: rtl/speaker_ctl.sv
// Left-justified I2S-style serializer: 512-clk frame, 16 bits per channel,
// MSB aligned with the lrck edge, clocks taken straight from a frame counter.
module speaker_ctl (
    input  logic         clk,
    input  logic         rst_n,   // asynchronous, active-high
    speaker_ctl_if.slave aud
);
    logic [8:0]  cnt_reg;
    logic [15:0] right_hold_reg;
    logic [15:0] shift_reg;
    logic [15:0] shift_next;
    logic [15:0] cap_left;
    logic [15:0] cap_right;
    logic        frame_end;
    logic        half_end;
    logic        bit_end;

    // Mute forces zero into both captured words.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mute
            assign cap_left[gi]  = aud.audio_left[gi]  & ~aud.mute;
            assign cap_right[gi] = aud.audio_right[gi] & ~aud.mute;
        end
    endgenerate

    assign frame_end = (cnt_reg == 9'd511);
    assign half_end  = (cnt_reg == 9'd255);
    assign bit_end   = (cnt_reg[3:0] == 4'hF);

    // Loads win over the sck-falling shift that shares their edge.
    always_comb begin
        shift_next = shift_reg;
        if (frame_end) begin
            shift_next = cap_left;
        end else if (half_end) begin
            shift_next = right_hold_reg;
        end else if (bit_end) begin
            shift_next = {shift_reg[14:0], 1'b0};
        end
    end

    // The left word goes straight into the shifter, so only right needs holding.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_reg        <= '0;
            right_hold_reg <= '0;
            shift_reg      <= '0;
        end else begin
            cnt_reg   <= cnt_reg + 9'd1;
            shift_reg <= shift_next;
            if (frame_end) begin
                right_hold_reg <= cap_right;
            end
        end
    end

    assign aud.audio_mclk = cnt_reg[1];
    assign aud.audio_sck  = cnt_reg[3];
    assign aud.audio_lrck = cnt_reg[8];
    assign aud.audio_sdin = shift_reg[15];
    assign aud.sample_req = frame_end;
endmodule

// File: tb/tb_speaker_ctl.sv
// Directed bench for speaker_ctl: clock ratios, frame contents, capture
// timing, mute and asynchronous reset, all against hand-computed values.
`timescale 1ns/1ps
module tb_speaker_ctl;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   m_cnt;

    speaker_ctl_if aud_if ();

    speaker_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .aud   (aud_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks elapsed since reset release, mod 512; used only as a time base.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) m_cnt <= 0;
        else       m_cnt <= (m_cnt + 1) % 512;
    end

    task automatic run_frame(input int ev_cnt, input logic [15:0] ev_l,
                             input logic [15:0] ev_r, input logic ev_m,
                             output logic [15:0] got_l, output logic [15:0] got_r);
        got_l = '0;
        got_r = '0;
        vectors++;
        if (m_cnt != 0) begin
            miscompares++;
            $display("FAIL frame_sync: tb counter at %0d, required 0", m_cnt);
        end
        for (int i = 0; i < 512; i++) begin
            if (i == ev_cnt) begin
                aud_if.audio_left  = ev_l;
                aud_if.audio_right = ev_r;
                aud_if.mute        = ev_m;
            end
            if ((i % 16) == 8) begin
                if (i < 256) got_l[15 - (i / 16)]         = aud_if.audio_sdin;
                else         got_r[15 - ((i - 256) / 16)] = aud_if.audio_sdin;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        aud_if.audio_left  = '0;
        aud_if.audio_right = '0;
        aud_if.mute        = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (aud_if.audio_mclk !== 1'b0) begin miscompares++; $display("FAIL rst_mclk: got %b, required 0", aud_if.audio_mclk); end
        if (aud_if.audio_sck  !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b, required 0", aud_if.audio_sck); end
        if (aud_if.audio_lrck !== 1'b0) begin miscompares++; $display("FAIL rst_lrck: got %b, required 0", aud_if.audio_lrck); end
        if (aud_if.audio_sdin !== 1'b0) begin miscompares++; $display("FAIL rst_sdin: got %b, required 0", aud_if.audio_sdin); end
        if (aud_if.sample_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b, required 0", aud_if.sample_req); end
        $display("reset: outputs held low during reset");
        rst_n = 1'b0;
    endtask

    // Starts at the negedge of release; every cycle checks the clock pins.
    task automatic test_clocks(input int ncyc);
        int e_mclk, e_sck, e_lrck, e_sdin, n_req, first_req;
        logic [8:0] c;
        e_mclk = 0; e_sck = 0; e_lrck = 0; e_sdin = 0; n_req = 0; first_req = -1;
        for (int i = 0; i < ncyc; i++) begin
            c = 9'(i % 512);
            if (aud_if.audio_mclk !== c[1]) e_mclk++;
            if (aud_if.audio_sck  !== c[3]) e_sck++;
            if (aud_if.audio_lrck !== c[8]) e_lrck++;
            if (aud_if.audio_sdin !== 1'b0) e_sdin++;
            if (aud_if.sample_req === 1'b1) begin
                if (c != 9'd511) n_req += 1000;
                else             n_req++;
                if (first_req < 0) first_req = i;
            end
            @(negedge clk);
        end
        vectors += 6;
        if (e_mclk != 0) begin miscompares++; $display("FAIL mclk_wave: %0d bad cycles, required 0", e_mclk); end
        if (e_sck  != 0) begin miscompares++; $display("FAIL sck_wave: %0d bad cycles, required 0", e_sck); end
        if (e_lrck != 0) begin miscompares++; $display("FAIL lrck_wave: %0d bad cycles, required 0", e_lrck); end
        if (e_sdin != 0) begin miscompares++; $display("FAIL zero_frame_sdin: %0d bad cycles, required 0", e_sdin); end
        if (n_req != ncyc / 512) begin miscompares++; $display("FAIL req_count: got %0d, required %0d", n_req, ncyc / 512); end
        if (first_req != 511) begin miscompares++; $display("FAIL first_req: got %0d clk after release, required 511", first_req); end
        $display("clocks: %0d cycles, first sample_req at %0d", ncyc, first_req);
    endtask

    task automatic test_frame_data();
        logic [15:0] l, r;
        rst_n = 1'b1;
        aud_if.audio_left  = 16'hB000;
        aud_if.audio_right = 16'h5FFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        run_frame(-1, '0, '0, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'h0000) begin miscompares++; $display("FAIL frame0_left: got %h, required 0000", l); end
        if (r !== 16'h0000) begin miscompares++; $display("FAIL frame0_right: got %h, required 0000", r); end
        $display("frame0: left %h right %h", l, r);
        run_frame(-1, '0, '0, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'hB000) begin miscompares++; $display("FAIL frame1_left: got %h, required b000", l); end
        if (r !== 16'h5FFF) begin miscompares++; $display("FAIL frame1_right: got %h, required 5fff", r); end
        $display("frame1: left %h right %h", l, r);
    endtask

    task automatic test_mid_frame_change();
        logic [15:0] l, r;
        run_frame(100, 16'h1234, 16'h5FFF, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'hB000) begin miscompares++; $display("FAIL inflight_left: got %h, required b000", l); end
        if (r !== 16'h5FFF) begin miscompares++; $display("FAIL inflight_right: got %h, required 5fff", r); end
        $display("change@100: left %h right %h", l, r);
        run_frame(-1, '0, '0, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'h1234) begin miscompares++; $display("FAIL next_left: got %h, required 1234", l); end
        if (r !== 16'h5FFF) begin miscompares++; $display("FAIL next_right: got %h, required 5fff", r); end
        $display("next frame: left %h right %h", l, r);
    endtask

    task automatic test_mute();
        logic [15:0] l, r;
        run_frame(500, 16'hFFFF, 16'hFFFF, 1'b1, l, r);
        vectors += 2;
        if (l !== 16'h1234) begin miscompares++; $display("FAIL premute_left: got %h, required 1234", l); end
        if (r !== 16'h5FFF) begin miscompares++; $display("FAIL premute_right: got %h, required 5fff", r); end
        $display("mute set@500: left %h right %h", l, r);
        run_frame(40, 16'hFFFF, 16'hFFFF, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'h0000) begin miscompares++; $display("FAIL muted_left: got %h, required 0000", l); end
        if (r !== 16'h0000) begin miscompares++; $display("FAIL muted_right: got %h, required 0000", r); end
        $display("muted frame, unmute@40: left %h right %h", l, r);
        run_frame(-1, '0, '0, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'hFFFF) begin miscompares++; $display("FAIL unmuted_left: got %h, required ffff", l); end
        if (r !== 16'hFFFF) begin miscompares++; $display("FAIL unmuted_right: got %h, required ffff", r); end
        $display("unmuted frame: left %h right %h", l, r);
    endtask

    task automatic test_back_to_back();
        logic [15:0] l, r;
        run_frame(500, 16'hA5A5, 16'h3C3C, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_prev_left: got %h, required ffff", l); end
        if (r !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_prev_right: got %h, required ffff", r); end
        $display("load a5a5/3c3c@500: left %h right %h", l, r);
        // Right changes one clk after sample_req; the old right must still go out.
        run_frame(0, 16'hA5A5, 16'hF0F0, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'hA5A5) begin miscompares++; $display("FAIL coherent_left: got %h, required a5a5", l); end
        if (r !== 16'h3C3C) begin miscompares++; $display("FAIL coherent_right: got %h, required 3c3c", r); end
        $display("right change@0: left %h right %h", l, r);
    endtask

    task automatic test_async_reset();
        logic [15:0] l, r;
        repeat (300) @(negedge clk);
        vectors += 3;
        if (aud_if.audio_sdin !== 1'b1) begin miscompares++; $display("FAIL pre_rst_sdin: got %b, required 1", aud_if.audio_sdin); end
        if (aud_if.audio_lrck !== 1'b1) begin miscompares++; $display("FAIL pre_rst_lrck: got %b, required 1", aud_if.audio_lrck); end
        if (aud_if.audio_sck  !== 1'b1) begin miscompares++; $display("FAIL pre_rst_sck: got %b, required 1", aud_if.audio_sck); end
        #2 rst_n = 1'b1;
        #1;
        vectors += 5;
        if (aud_if.audio_sdin !== 1'b0) begin miscompares++; $display("FAIL async_sdin: got %b, required 0", aud_if.audio_sdin); end
        if (aud_if.audio_lrck !== 1'b0) begin miscompares++; $display("FAIL async_lrck: got %b, required 0", aud_if.audio_lrck); end
        if (aud_if.audio_sck  !== 1'b0) begin miscompares++; $display("FAIL async_sck: got %b, required 0", aud_if.audio_sck); end
        if (aud_if.audio_mclk !== 1'b0) begin miscompares++; $display("FAIL async_mclk: got %b, required 0", aud_if.audio_mclk); end
        if (aud_if.sample_req !== 1'b0) begin miscompares++; $display("FAIL async_req: got %b, required 0", aud_if.sample_req); end
        $display("async reset@cnt300: outputs cleared before next clk edge");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        test_clocks(512);
        run_frame(-1, '0, '0, 1'b0, l, r);
        vectors += 2;
        if (l !== 16'hA5A5) begin miscompares++; $display("FAIL post_rst_left: got %h, required a5a5", l); end
        if (r !== 16'hF0F0) begin miscompares++; $display("FAIL post_rst_right: got %h, required f0f0", r); end
        $display("post-reset frame1: left %h right %h", l, r);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        aud_if.audio_left  = '0;
        aud_if.audio_right = '0;
        aud_if.mute        = 1'b0;
        test_reset();
        test_clocks(1024);
        test_frame_data();
        test_mid_frame_change();
        test_mute();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
